// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
// Shared definitions for the VGA frame compositor:
//   - default 640x480@60 timing (pixels / lines) and the derived totals
//   - rgb332_t colour type and helpers that split it into the three VGA fields
// -----------------------------------------------------------------------------
package vga_pkg;

    localparam int DEF_H_VISIBLE = 640;
    localparam int DEF_H_FRONT   = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BACK    = 48;
    localparam int DEF_V_VISIBLE = 480;
    localparam int DEF_V_FRONT   = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BACK    = 33;

    localparam int H_TOTAL = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
    localparam int V_TOTAL = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

    typedef logic [7:0] rgb332_t;

    function automatic logic [2:0] rgb332_red(input rgb332_t c);
        return c[7:5];
    endfunction

    function automatic logic [2:0] rgb332_green(input rgb332_t c);
        return c[4:2];
    endfunction

    function automatic logic [1:0] rgb332_blue(input rgb332_t c);
        return c[1:0];
    endfunction

endpackage

// File: rtl/vga_frame_compositor_if.sv
// -----------------------------------------------------------------------------
// vga_frame_compositor_if
// Bundles the compositor's raster, sprite-layer and VGA-pin signals.
//   master : the compositor (drives raster, sprite_en and pins)
//   slave  : the environment (pixel tick source, sprite layers, pin sink)
// Signals:
//   pixel_tick  one-clock pulse per pixel period
//   sprite_en   copy of pixel_tick for the sprite enables
//   hcount/vcount  raster position (10 bits each)
//   layer_data  per-layer pixel-present flags, layer_rgb per-layer RGB332
//   red/green/blue, hsync/vsync (active low), frame_start
// -----------------------------------------------------------------------------
interface vga_frame_compositor_if #(
    parameter int NUM_LAYERS = 4
);
    logic                    pixel_tick;
    logic                    sprite_en;
    logic [9:0]              hcount;
    logic [9:0]              vcount;
    logic [NUM_LAYERS-1:0]   layer_data;
    logic [8*NUM_LAYERS-1:0] layer_rgb;
    logic [2:0]              red;
    logic [2:0]              green;
    logic [1:0]              blue;
    logic                    hsync;
    logic                    vsync;
    logic                    frame_start;

    modport master (
        input  pixel_tick, layer_data, layer_rgb,
        output sprite_en, hcount, vcount, red, green, blue, hsync, vsync, frame_start
    );

    modport slave (
        output pixel_tick, layer_data, layer_rgb,
        input  sprite_en, hcount, vcount, red, green, blue, hsync, vsync, frame_start
    );
endinterface

// File: rtl/vga_timing.sv
// -----------------------------------------------------------------------------
// vga_timing
// Raster counters (stage S0) plus the raw per-position flags derived from them.
// Ports:
//   clock, reset      system clock, synchronous active-high reset
//   i_tick            pixel tick; counters advance only when it is high
//   o_hcount/o_vcount registered raster position
//   o_hsync_raw       active-low horizontal sync for the current position
//   o_vsync_raw       active-low vertical sync for the current position
//   o_visible         position lies inside the visible area
//   o_first           position is (0,0)
// -----------------------------------------------------------------------------
module vga_timing
    import vga_pkg::*;
#(
    parameter int H_VISIBLE = DEF_H_VISIBLE,
    parameter int H_FRONT   = DEF_H_FRONT,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BACK    = DEF_H_BACK,
    parameter int V_VISIBLE = DEF_V_VISIBLE,
    parameter int V_FRONT   = DEF_V_FRONT,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BACK    = DEF_V_BACK
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       i_tick,
    output logic [9:0] o_hcount,
    output logic [9:0] o_vcount,
    output logic       o_hsync_raw,
    output logic       o_vsync_raw,
    output logic       o_visible,
    output logic       o_first
);

    localparam logic [9:0] H_LAST   = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [9:0] V_LAST   = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] H_SYN_LO = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] H_SYN_HI = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] V_SYN_LO = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] V_SYN_HI = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [9:0] r_hcount;
    logic [9:0] r_vcount;

    // S0: raster counters
    always_ff @(posedge clock) begin
        if (reset) begin
            r_hcount <= '0;
            r_vcount <= '0;
        end else if (i_tick) begin
            if (r_hcount == H_LAST) begin
                r_hcount <= '0;
                r_vcount <= (r_vcount == V_LAST) ? 10'd0 : r_vcount + 10'd1;
            end else begin
                r_hcount <= r_hcount + 10'd1;
            end
        end
    end

    assign o_hcount    = r_hcount;
    assign o_vcount    = r_vcount;
    assign o_hsync_raw = !((r_hcount >= H_SYN_LO) && (r_hcount < H_SYN_HI));
    assign o_vsync_raw = !((r_vcount >= V_SYN_LO) && (r_vcount < V_SYN_HI));
    assign o_visible   = (r_hcount < H_VIS) && (r_vcount < V_VIS);
    assign o_first     = (r_hcount == 10'd0) && (r_vcount == 10'd0);

endmodule

// File: rtl/vga_frame_compositor.sv
// -----------------------------------------------------------------------------
// vga_frame_compositor
// Generates the VGA raster, delays the sync/visible/first flags to match the
// sprite read latency, priority-muxes the sprite layers (index 0 highest) over
// BG_COLOR, blanks outside the visible area and drives the VGA pins.
// Counter value to pin latency is two pixel ticks (S0 counters, S1 sprites,
// S2 compositor register).
// Ports:
//   clock, reset  system clock, synchronous active-high reset (wins over a tick)
//   bus           vga_frame_compositor_if.master (tick, layers, raster, pins)
// Optional feature: define VGA_DEBUG_BORDER_EN to force visible edge pixels
// to white above all layers.
// -----------------------------------------------------------------------------
module vga_frame_compositor
    import vga_pkg::*;
#(
    parameter int      H_VISIBLE  = DEF_H_VISIBLE,
    parameter int      H_FRONT    = DEF_H_FRONT,
    parameter int      H_SYNC     = DEF_H_SYNC,
    parameter int      H_BACK     = DEF_H_BACK,
    parameter int      V_VISIBLE  = DEF_V_VISIBLE,
    parameter int      V_FRONT    = DEF_V_FRONT,
    parameter int      V_SYNC     = DEF_V_SYNC,
    parameter int      V_BACK     = DEF_V_BACK,
    parameter int      NUM_LAYERS = 4,
    parameter rgb332_t BG_COLOR   = 8'b111_111_11
) (
    input logic                   clock,
    input logic                   reset,
    vga_frame_compositor_if.master bus
);

    logic [9:0] w_hcount;
    logic [9:0] w_vcount;
    logic       w_hsync_raw;
    logic       w_vsync_raw;
    logic       w_visible;
    logic       w_first;
    logic       w_tick;
    rgb332_t    w_pixel;

    logic       r_hsync_p1, r_vsync_p1, r_vis_p1, r_first_p1;
    logic       r_hsync_p2, r_vsync_p2, r_first_p2;
    rgb332_t    r_rgb_p2;

    assign w_tick = bus.pixel_tick;

    vga_timing #(
        .H_VISIBLE (H_VISIBLE), .H_FRONT (H_FRONT), .H_SYNC (H_SYNC), .H_BACK (H_BACK),
        .V_VISIBLE (V_VISIBLE), .V_FRONT (V_FRONT), .V_SYNC (V_SYNC), .V_BACK (V_BACK)
    ) u_timing (
        .clock       (clock),
        .reset       (reset),
        .i_tick      (w_tick),
        .o_hcount    (w_hcount),
        .o_vcount    (w_vcount),
        .o_hsync_raw (w_hsync_raw),
        .o_vsync_raw (w_vsync_raw),
        .o_visible   (w_visible),
        .o_first     (w_first)
    );

    // Lowest-index layer with data wins; scanning from the top index down lets
    // each lower index overwrite the choice.
    function automatic rgb332_t prio_mux(input logic [NUM_LAYERS-1:0]   data,
                                         input logic [8*NUM_LAYERS-1:0] rgb);
        rgb332_t c;
        c = BG_COLOR;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (data[i]) c = rgb[8*i +: 8];
        end
        return c;
    endfunction

`ifdef VGA_DEBUG_BORDER_EN
    localparam logic [9:0] H_EDGE = 10'(H_VISIBLE - 1);
    localparam logic [9:0] V_EDGE = 10'(V_VISIBLE - 1);
    logic r_border_p1;

    // S1: border flag travels with the other delayed position flags
    always_ff @(posedge clock) begin
        if (reset) begin
            r_border_p1 <= 1'b0;
        end else if (w_tick) begin
            r_border_p1 <= (w_hcount == 10'd0) || (w_hcount == H_EDGE) ||
                           (w_vcount == 10'd0) || (w_vcount == V_EDGE);
        end
    end
`endif

    always_comb begin
        w_pixel = prio_mux(bus.layer_data, bus.layer_rgb);
`ifdef VGA_DEBUG_BORDER_EN
        if (r_border_p1) w_pixel = 8'hFF;
`endif
        if (!r_vis_p1) w_pixel = '0;
    end

    // S1 and S2: flag delay line and compositor output register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_hsync_p1 <= 1'b1;
            r_vsync_p1 <= 1'b1;
            r_vis_p1   <= 1'b0;
            r_first_p1 <= 1'b0;
            r_hsync_p2 <= 1'b1;
            r_vsync_p2 <= 1'b1;
            r_first_p2 <= 1'b0;
            r_rgb_p2   <= '0;
        end else begin
            // frame_start is a single-clock pulse, so it clears on every non-tick clock
            r_first_p2 <= w_tick && r_first_p1;
            if (w_tick) begin
                r_hsync_p1 <= w_hsync_raw;
                r_vsync_p1 <= w_vsync_raw;
                r_vis_p1   <= w_visible;
                r_first_p1 <= w_first;
                r_hsync_p2 <= r_hsync_p1;
                r_vsync_p2 <= r_vsync_p1;
                r_rgb_p2   <= w_pixel;
            end
        end
    end

    assign bus.sprite_en   = w_tick;
    assign bus.hcount      = w_hcount;
    assign bus.vcount      = w_vcount;
    assign bus.red         = rgb332_red(r_rgb_p2);
    assign bus.green       = rgb332_green(r_rgb_p2);
    assign bus.blue        = rgb332_blue(r_rgb_p2);
    assign bus.hsync       = r_hsync_p2;
    assign bus.vsync       = r_vsync_p2;
    assign bus.frame_start = r_first_p2;

endmodule
